// File: rtl/win_acc_pkg.sv
// Shared constants, state encoding and default widths for the Winograd accumulator stage.
package win_acc_pkg;

  localparam int MAX_BEATS_DEF = 256;
  localparam int ACC16_W_DEF   = 40;
  localparam int LANE_W_DEF    = 24;
  localparam int OUT_W         = 96;
  localparam int NUM_LANES     = 4;

  localparam logic [1:0]  BW_16       = 2'b00;
  localparam logic [1:0]  BW_8        = 2'b11;
  localparam logic [31:0] NEG_ZERO_32 = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/win_acc_lane.sv
// One 8-bit-mode lane: sign-extends a 16-bit product and loads or adds it into a LANE_W accumulator.
module win_acc_lane
  import win_acc_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              add,
  input  logic [15:0]       din,
  output logic [LANE_W-1:0] acc
);

  logic [LANE_W-1:0] acc_q;
  logic [LANE_W-1:0] acc_d;
  logic [LANE_W-1:0] din_ext;

  always_comb begin
    din_ext = {{(LANE_W-16){din[15]}}, din};
    acc_d   = acc_q;
    if (load) begin
      acc_d = din_ext;
    end else if (add) begin
      acc_d = acc_q + din_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/win_acc_stage.sv
// Group accumulator behind the Winograd multiplier: sums one group of products (one 32-bit
// product or four 16-bit lanes per beat) and hands the result downstream over valid/ready.
module win_acc_stage
  import win_acc_pkg::*;
#(
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int ACC16_W   = ACC16_W_DEF,
  parameter int LANE_W    = LANE_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  bitwidth,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] out_data,
  output logic        out_mode8,
  output logic        out_trunc
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_t             state_q, state_d;
  logic               mode8_q, mode8_d;
  logic               trunc_q, trunc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_inc;
  logic [ACC16_W-1:0] acc16_q, acc16_d;
  logic [ACC16_W-1:0] prod_ext;
  logic [31:0]        prod32;
  logic               beat_fire;
  logic               lane_load;
  logic               lane_add;
  logic [LANE_W-1:0]  lane_acc [NUM_LANES];

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_mode8 = mode8_q;
  assign out_trunc = trunc_q;

  assign beat_fire = in_valid && in_ready;
  assign lane_load = beat_fire && (state_q == IDLE);
  assign lane_add  = beat_fire && (state_q == ACC);
  assign count_inc = count_q + CNT_W'(1);

  // The multiplier can emit 0x80000000 as a signed zero; fold it to a true zero.
  assign prod32   = (in_data[31:0] == NEG_ZERO_32) ? 32'd0 : in_data[31:0];
  assign prod_ext = {{(ACC16_W-32){prod32[31]}}, prod32};

  always_comb begin
    state_d = state_q;
    mode8_d = mode8_q;
    trunc_d = trunc_q;
    count_d = count_q;
    acc16_d = acc16_q;
    case (state_q)
      IDLE: begin
        if (beat_fire) begin
          mode8_d = (bitwidth == BW_8);
          trunc_d = 1'b0;
          acc16_d = prod_ext;
          count_d = CNT_W'(1);
          state_d = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (beat_fire) begin
          acc16_d = acc16_q + prod_ext;
          count_d = count_inc;
          if (in_last || (count_inc == MAX_CNT)) begin
            state_d = HOLD;
            trunc_d = !in_last;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode8_q <= 1'b0;
      trunc_q <= 1'b0;
      count_q <= '0;
      acc16_q <= '0;
    end else begin
      state_q <= state_d;
      mode8_q <= mode8_d;
      trunc_q <= trunc_d;
      count_q <= count_d;
      acc16_q <= acc16_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      win_acc_lane #(
        .LANE_W (LANE_W)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lane_load),
        .add   (lane_add),
        .din   (in_data[16*gi +: 16]),
        .acc   (lane_acc[gi])
      );
    end
  endgenerate

  always_comb begin
    out_data = '0;
    if (mode8_q) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        out_data[LANE_W*i +: LANE_W] = lane_acc[i];
      end
    end else begin
      out_data = {{(OUT_W-ACC16_W){acc16_q[ACC16_W-1]}}, acc16_q};
    end
  end

endmodule

// File: tb/tb_win_acc_stage.sv
// Randomized scoreboard bench for win_acc_stage with a behavioural group-sum reference model.
module tb_win_acc_stage;
  import win_acc_pkg::*;

  localparam int MAXB = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [1:0]  bitwidth = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] out_data;
  logic        out_mode8;
  logic        out_trunc;

  win_acc_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bitwidth  (bitwidth),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode8 (out_mode8),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] data;
    logic        mode8;
    logic        trunc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  bit     rand_ready = 1'b0;

  // Reference model state: running group sums in plain integers.
  int     m_count = 0;
  bit     m_mode8 = 1'b0;
  longint m_sum16 = 0;
  int     m_lane[4];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic model_beat(input logic [63:0] d, input logic l, input logic [1:0] bw);
    exp_t              e;
    logic [31:0]       lane_bits;
    logic signed [95:0] s96;
    if (m_count == 0) begin
      m_mode8 = (bw == 2'b11);
      m_sum16 = 0;
      for (int k = 0; k < 4; k++) m_lane[k] = 0;
    end
    if (m_mode8) begin
      for (int k = 0; k < 4; k++) m_lane[k] += int'($signed(d[16*k +: 16]));
    end else if (d[31:0] != 32'h8000_0000) begin
      m_sum16 += longint'($signed(d[31:0]));
    end
    m_count++;
    if (l || m_count == MAXB) begin
      e.mode8 = m_mode8;
      e.trunc = !l;
      e.data  = '0;
      if (m_mode8) begin
        for (int k = 0; k < 4; k++) begin
          lane_bits = m_lane[k];
          e.data[24*k +: 24] = lane_bits[23:0];
        end
      end else begin
        s96 = m_sum16;
        e.data = s96;
      end
      exp_q.push_back(e);
      m_count = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_beat(input logic [63:0] d, input logic l, input logic [1:0] bw, input int gap);
    int w;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    model_beat(d, l, bw);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    bitwidth = bw;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 500);
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 500 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = {$urandom, $urandom};
    bitwidth = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 96'(in_ready), 96'd1);
    check({tag, "_out_valid"}, 96'(out_valid), 96'd0);
    check({tag, "_out_data"}, out_data, 96'd0);
    check({tag, "_out_mode8"}, 96'(out_mode8), 96'd0);
    check({tag, "_out_trunc"}, 96'(out_trunc), 96'd0);
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops an expected result each time the DUT hands one over.
  bit          prev_hold = 1'b0;
  logic [97:0] prev_word = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 96'(out_valid), 96'd1);
        check("hold_stable", 96'({out_trunc, out_mode8, out_data}), 96'(prev_word));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("res_data", out_data, e.data);
          check("res_mode8", 96'(out_mode8), 96'(e.mode8));
          check("res_trunc", 96'(out_trunc), 96'(e.trunc));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_word = {out_trunc, out_mode8, out_data};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  bw_g;
    logic [63:0] d;
    int          len;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_ready = 1'b1;

    // Basic 16-bit sum; mid-group bitwidth change and upper half must be ignored.
    send_beat(64'h0000_0000_0000_0064, 1'b0, BW_16, 0);
    send_beat(64'hDEAD_BEEF_FFFF_FF9C, 1'b0, BW_8, 0);
    send_beat(64'h0000_0000_0000_0005, 1'b1, BW_8, 0);
    @(negedge clk);
    check("latency_valid", 96'(out_valid), 96'd1);
    check("latency_data", out_data, 96'd5);

    // Negative zero folds to 0.
    send_beat(64'h0000_0000_8000_0000, 1'b0, BW_16, 1);
    send_beat(64'h0000_0000_0000_0007, 1'b1, BW_16, 0);

    // 8-bit mode, lanes independent.
    send_beat(64'h0001_FFFF_7FFF_8000, 1'b0, BW_8, 1);
    send_beat(64'h0001_0001_7FFF_8000, 1'b1, BW_16, 0);

    // Forced close at MAX_BEATS, then the next beat opens a fresh group.
    for (int i = 0; i < MAXB; i++) send_beat(64'h0000_0000_7FFF_FFFF, 1'b0, BW_16, 0);
    send_beat(64'h0000_0000_0000_0003, 1'b1, BW_16, 0);
    wait_drain();

    // Backpressure: result held for 5 cycles, accepted on the 6th.
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send_beat(64'h0000_0000_0000_1234, 1'b1, BW_16, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 96'(in_ready), 96'd0);
      check("bp_out_data", out_data, 96'h1234);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_in_ready", 96'(in_ready), 96'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_in_ready", 96'(in_ready), 96'd1);
    check("bp_after_out_valid", 96'(out_valid), 96'd0);
    rand_ready = 1'b1;
    @(posedge clk);
    #2;

    // Reset mid-group discards partial sums.
    send_beat(64'd11, 1'b0, BW_16, 0);
    send_beat(64'd22, 1'b0, BW_16, 0);
    send_beat(64'd33, 1'b0, BW_16, 0);
    rst_n = 1'b0;
    m_count = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(64'h0000_0000_0000_0009, 1'b1, BW_16, 0);
    wait_drain();

    // Random groups, mixed modes, random gaps and backpressure.
    for (int g = 0; g < 40; g++) begin
      bw_g = 2'($urandom_range(0, 3));
      len  = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        if (bw_g == BW_8) d = {$urandom, $urandom};
        else d = {$urandom, ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom)};
        send_beat(d, (b == len - 1), (b == 0) ? bw_g : 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2));
      end
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
